// File: rtl/csa_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-select adder among NUM_REQ requesters.
// Two-stage pipeline: S1 captures the granted operands, S2 holds the tagged response.
module csa_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] a_in,
  input  logic [NUM_REQ*32-1:0] b_in,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout
);

  localparam int unsigned BlkW   = 4;
  localparam int unsigned NumBlk = 32 / BlkW;

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            stall;
  logic            s1_free;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [31:0]     add_p;
  logic [31:0]     add_g;
  logic [31:0]     add_sum;
  logic            add_cout;

  assign stall   = rsp_valid_q & ~rsp_ready;
  assign s1_free = ~s1_valid_q | ~stall;

  // Search from ptr upward with wrap; no grant while in reset or while S1 cannot accept.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    if (rst_n && s1_free) begin
      for (int unsigned o = 0; o < NUM_REQ; o++) begin
        idx = 32'(ptr_q) + o;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_vld && req[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
      if (grant_vld) begin
        gnt[grant_idx] = 1'b1;
        ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  // Carry-select adder: each 4-bit block ripples for both carry-ins, block carry picks one.
  assign add_p = s1_a_q ^ s1_b_q;
  assign add_g = s1_a_q & s1_b_q;

  always_comb begin
    logic            c_blk;
    logic            c0;
    logic            c1;
    logic [BlkW-1:0] s0;
    logic [BlkW-1:0] s1;
    c_blk   = 1'b0;
    c0      = 1'b0;
    c1      = 1'b1;
    s0      = '0;
    s1      = '0;
    add_sum = '0;
    for (int unsigned k = 0; k < NumBlk; k++) begin
      c0 = 1'b0;
      c1 = 1'b1;
      for (int unsigned j = 0; j < BlkW; j++) begin
        s0[j] = add_p[k*BlkW+j] ^ c0;
        s1[j] = add_p[k*BlkW+j] ^ c1;
        c0    = add_g[k*BlkW+j] | (add_p[k*BlkW+j] & c0);
        c1    = add_g[k*BlkW+j] | (add_p[k*BlkW+j] & c1);
      end
      add_sum[k*BlkW +: BlkW] = c_blk ? s1 : s0;
      c_blk = c_blk ? c1 : c0;
    end
    add_cout = c_blk;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    if (s1_free) begin
      s1_valid_d = grant_vld;
      if (grant_vld) begin
        s1_a_d  = a_in[{grant_idx, 5'd0} +: 32];
        s1_b_d  = b_in[{grant_idx, 5'd0} +: 32];
        s1_id_d = grant_idx;
      end
    end
    if (!stall) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_csa_adder_arbiter.sv
// Bench for csa_adder_arbiter: reference arbiter/occupancy model feeding a result scoreboard,
// directed corner cases followed by random request/backpressure traffic.
module tb_csa_adder_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [32:0]     res;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] a_in;
  logic [NUM_REQ*32-1:0] b_in;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;

  exp_t               exp_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic               m_s1v;
  logic               m_rspv;
  int unsigned        m_ptr;
  logic [NUM_REQ-1:0] last_gnt;
  logic               hold_chk;
  logic [31:0]        hold_sum;
  logic               hold_cout;
  logic [ID_W-1:0]    hold_id;

  csa_adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1v    = 1'b0;
    m_rspv   = 1'b0;
    m_ptr    = 0;
    hold_chk = 1'b0;
    last_gnt = '0;
    exp_q.delete();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    a_in[i*32 +: 32] = a;
    b_in[i*32 +: 32] = b;
  endtask

  // Called just after a falling edge with inputs already driven; ends at the next falling edge.
  task automatic step(input bit use_want, input logic [NUM_REQ-1:0] want);
    logic               stall;
    logic               s1_free;
    int                 g;
    int unsigned        idx;
    logic [NUM_REQ-1:0] eg;
    exp_t               e;
    #1;
    stall   = m_rspv & ~rsp_ready;
    s1_free = ~m_s1v | ~stall;
    g       = -1;
    eg      = '0;
    if (s1_free) begin
      for (int o = 0; o < NUM_REQ; o++) begin
        idx = (m_ptr + o) % NUM_REQ;
        if (g < 0 && req[idx]) g = int'(idx);
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", gnt, eg);
    if (use_want) check("dir_gnt", gnt, want);
    check("rsp_valid", rsp_valid, m_rspv);
    if (hold_chk) begin
      check("hold_sum", rsp_sum, hold_sum);
      check("hold_cout", rsp_cout, hold_cout);
      check("hold_id", rsp_id, hold_id);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_sum", rsp_sum, e.res[31:0]);
        check("rsp_cout", rsp_cout, e.res[32]);
      end
    end
    hold_chk  = rsp_valid & ~rsp_ready;
    hold_sum  = rsp_sum;
    hold_cout = rsp_cout;
    hold_id   = rsp_id;
    if (g >= 0) begin
      e.id  = ID_W'(g);
      e.res = {1'b0, a_in[g*32 +: 32]} + {1'b0, b_in[g*32 +: 32]};
      exp_q.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
    end
    if (!stall) m_rspv = m_s1v;
    if (s1_free) m_s1v = (g >= 0);
    last_gnt = eg;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '1;
    a_in      = '0;
    b_in      = '0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, '0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_sum", rsp_sum, 32'd0);
    check("rst_cout", rsp_cout, 1'b0);
    check("rst_id", rsp_id, '0);
    rst_n = 1'b1;
    req   = '0;

    // Single op, result two cycles after the grant
    set_op(0, 32'h0000_0005, 32'h0000_0003);
    req = 4'b0001;
    step(1'b1, 4'b0001);
    req = '0;
    step(1'b0, '0);
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_sum", rsp_sum, 32'd8);
    check("t1_id", rsp_id, '0);
    repeat (2) step(1'b0, '0);

    // Carry wrap cases
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    req = 4'b0001;
    step(1'b1, 4'b0001);
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    step(1'b1, 4'b0001);
    req = '0;
    step(1'b0, '0);
    check("t2_sum_a", rsp_sum, 32'd0);
    check("t2_cout_a", rsp_cout, 1'b1);
    step(1'b0, '0);
    check("t2_sum_b", rsp_sum, 32'd0);
    check("t2_cout_b", rsp_cout, 1'b1);
    repeat (2) step(1'b0, '0);

    // Round robin with all requesters held
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h1000_0000 * i + 32'h11, 32'h0000_0100 + i);
    req = '1;
    for (int k = 0; k < 9; k++) begin
      set_op(k % NUM_REQ, $urandom, $urandom);
      step(1'b0, '0);
    end
    req = '0;
    repeat (3) step(1'b0, '0);

    // Backpressure: two grants fill the pipe, then nothing until release
    req       = '1;
    rsp_ready = 1'b0;
    repeat (5) step(1'b0, '0);
    rsp_ready = 1'b1;
    repeat (4) step(1'b0, '0);
    req = '0;
    repeat (3) step(1'b0, '0);

    // Fairness: move ptr to 2, then req=0011 wraps to 0
    req = 4'b0010;
    step(1'b1, 4'b0010);
    req = 4'b0011;
    step(1'b1, 4'b0001);
    req = 4'b0010;
    step(1'b1, 4'b0010);
    req = '0;
    repeat (3) step(1'b0, '0);

    // Reset with both stages full
    req       = '1;
    rsp_ready = 1'b0;
    repeat (3) step(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_gnt", gnt, '0);
    check("mid_rst_sum", rsp_sum, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step(1'b1, 4'b0001);
    req = 4'b0100;
    step(1'b1, 4'b0100);
    req = '0;
    repeat (3) step(1'b0, '0);

    // Random traffic; a request not yet granted keeps its operands
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!(req[i] && !last_gnt[i])) begin
          req[i] = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 7) == 0) set_op(i, 32'hFFFF_FFFF, $urandom_range(0, 2));
          else set_op(i, $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1'b0, '0);
    end
    req       = '0;
    rsp_ready = 1'b1;
    repeat (4) step(1'b0, '0);
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
